iob_axistream_out_pkt: RTL and testbench
========================================

Name: iob_axistream_out_pkt

Overview:
Parametrised AXI-Stream output packetiser. It accepts DATA_W-bit words with per-lane strobe and a last flag from a CPU/DMA write port and buffers them in an internal synchronous FIFO. It unpacks each word into TDATA_W-bit beats, skipping disabled lanes, on a registered, AXIS-compliant output. It can also insert TLAST automatically every PKT_LEN beats. It sits between the register/DMA side and an AXIS sink in a single clock domain.

Parameters:
DATA_W, 32, input word width; must be a multiple of TDATA_W.
TDATA_W, 8, output beat width; N = DATA_W/TDATA_W lanes per word, N >= 1.
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in words.
PKT_LEN_W, 16, width of the auto-last length and beat counter.

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; 0 freezes all state
rst_i  in  1  synchronous active-high reset
enable_i  in  1  allows new beats to be loaded into the output register
auto_last_en_i  in  1  enables automatic TLAST insertion
pkt_len_i  in  PKT_LEN_W  beats per auto packet; 0 = auto-last off
threshold_i  in  FIFO_DEPTH_LOG2+1  level threshold
w_valid_i  in  1  write request
w_data_i  in  DATA_W  write word; lane 0 = bits [TDATA_W-1:0], sent first
w_strb_i  in  N  lane enables
w_last_i  in  1  word ends a packet
w_ready_o  out  1  FIFO can accept a word
fifo_level_o  out  FIFO_DEPTH_LOG2+1  words stored
fifo_empty_o  out  1  level == 0
fifo_full_o  out  1  level == 2^FIFO_DEPTH_LOG2
fifo_threshold_o  out  1  level <= threshold_i
axis_tvalid_o  out  1  beat valid
axis_tready_i  in  1  sink ready
axis_tdata_o  out  TDATA_W  beat data
axis_tlast_o  out  1  beat ends packet

Behaviour:
- Single clock domain; rst_i is synchronous and active-high. rst_i takes priority over cke_i and clears all state.
- Reset values: axis_tvalid_o=0, axis_tdata_o=0, axis_tlast_o=0, fifo_level_o=0, fifo_empty_o=1, fifo_full_o=0, w_ready_o=1, fifo_threshold_o=1. The beat counter and unpacker state are cleared.
- Write side: a word is pushed when w_valid_i & w_ready_o. w_ready_o = ~full; there is no pass-through when full, even with a simultaneous pop.
- Push and pop in the same cycle leave the level unchanged. Pointers wrap modulo depth.
- Unpacker states:
  - IDLE: no word held. If the FIFO is not empty, pop one word and go to UNPACK.
  - UNPACK: holds word, strobe, last and the current lane index.
  - A word with strobe == 0 is discarded entirely, including its last flag, and produces no beat.
- Lane selection:
  - The current lane is the lowest set strobe bit at or above the lane index.
  - The final lane is the highest set strobe bit.
  - After the final lane is emitted, pop the next word in the same cycle if one is available (back-to-back, no bubble); otherwise go to IDLE.
- Output register:
  - Load a new beat when (~axis_tvalid_o | axis_tready_i) & enable_i & a lane is available.
  - While axis_tvalid_o & ~axis_tready_i, tdata and tlast hold stable.
  - enable_i=0 never withdraws a presented beat. It only blocks loading; tvalid drops after the current beat is accepted.
  - Throughput is 1 beat/cycle.
- Latency: a write handshake at edge k gives axis_tvalid_o=1 after edge k+2 (FIFO empty, output idle, enable_i=1).
- TLAST is the OR of two terms:
  - (word last & final lane), and
  - (auto_last_en_i & pkt_len_i != 0 & cnt == pkt_len_i-1).
- Beat counter cnt:
  - Increments on each beat load.
  - Clears to 0 when the loaded beat has tlast=1.
  - Wraps at 2^PKT_LEN_W.
  - If pkt_len_i changes so that cnt > pkt_len_i-1, the beat at cnt wrap is not marked; auto TLAST resumes after the counter is cleared by a software last.
- Reset mid-operation: the in-flight beat is dropped even if tvalid is high, and the FIFO contents are lost.
- cke_i=0: all registers hold; w_ready_o still reflects ~full, but no push occurs.

Test Plan:
- DATA_W=32, TDATA_W=8, write 0x44332211, strb 4'b1111, last=1, tready=1 -> beats 0x11, 0x22, 0x33, 0x44 in 4 consecutive cycles; tlast only on 0x44; first tvalid 2 cycles after the write.
- Write 0xDDCCBBAA strb 4'b0101 last=1, then a strb 4'b0000 word, then 0x88776655 strb 4'b1000 last=0 -> beats 0xAA, 0xCC(tlast), 0x88; no beat for the zero-strobe word.
- Backpressure: during a 4-beat word, hold tready=0 for 3 cycles at beat 2 -> tdata stays 0x22 with tvalid=1; no beat lost or duplicated; total 4 handshakes.
- auto_last_en_i=1, pkt_len_i=3, two full words, the second with last=1 -> 8 beats with tlast on beats 3, 6 and 8; a following packet's first tlast is on its beat 3.
- enable_i=0, write 16 words, threshold_i=4 -> level 16, full=1, w_ready_o=0, threshold=0; a 17th write is not accepted. Then enable_i=1, tready=1 -> 64 beats in 64 consecutive cycles; empty=1 at the end.
- Assert rst_i for 1 cycle mid-packet with tvalid=1 -> the next cycle shows tvalid=0, level=0, w_ready_o=1; a new pkt_len_i=3 stream asserts tlast on its beat 3.

Source files
------------

// File: rtl/iob_axistream_out_pkt.sv
// iob_axistream_out_pkt: FIFO-buffered word-to-beat AXI-Stream packetiser with strobe skipping and auto TLAST
module iob_axistream_out_pkt #(
  parameter int DATA_W          = 32,
  parameter int TDATA_W         = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PKT_LEN_W       = 16
) (
  input  logic                        clk_i,
  input  logic                        cke_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        auto_last_en_i,
  input  logic [PKT_LEN_W-1:0]        pkt_len_i,
  input  logic [FIFO_DEPTH_LOG2:0]    threshold_i,
  input  logic                        w_valid_i,
  input  logic [DATA_W-1:0]           w_data_i,
  input  logic [DATA_W/TDATA_W-1:0]   w_strb_i,
  input  logic                        w_last_i,
  output logic                        w_ready_o,
  output logic [FIFO_DEPTH_LOG2:0]    fifo_level_o,
  output logic                        fifo_empty_o,
  output logic                        fifo_full_o,
  output logic                        fifo_threshold_o,
  output logic                        axis_tvalid_o,
  input  logic                        axis_tready_i,
  output logic [TDATA_W-1:0]          axis_tdata_o,
  output logic                        axis_tlast_o
);
  localparam int N     = DATA_W / TDATA_W;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam int EW    = DATA_W + N + 1;

  typedef enum logic {IDLE, UNPACK} state_t;
  state_t state, state_n;

  logic [EW-1:0]              mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr, rptr;
  logic [LW-1:0]              level;
  logic [EW-1:0]              rd;
  logic                       push, pop, can_load, final_lane, auto_hit, lane_last, hold_last;
  logic [DATA_W-1:0]          word;
  logic [N-1:0]               rem, rem_n, lane_oh;
  logic [TDATA_W-1:0]         beat;
  logic [PKT_LEN_W-1:0]       cnt;

  assign fifo_level_o     = level;
  assign fifo_empty_o     = level == '0;
  assign fifo_full_o      = level == LW'(DEPTH);
  assign fifo_threshold_o = level <= threshold_i;
  assign w_ready_o        = ~fifo_full_o;
  assign push             = cke_i & w_valid_i & w_ready_o;
  assign rd               = mem[rptr];

  assign lane_oh    = rem & (~rem + N'(1));
  assign final_lane = (rem & (rem - N'(1))) == '0;
  assign can_load   = (state == UNPACK) & (~axis_tvalid_o | axis_tready_i) & enable_i;
  assign pop        = enable_i & ~fifo_empty_o & ((state == IDLE) | (can_load & final_lane));
  assign auto_hit   = auto_last_en_i & (pkt_len_i != '0) & (cnt == pkt_len_i - PKT_LEN_W'(1));
  assign lane_last  = (hold_last & final_lane) | auto_hit;

  always_comb begin
    beat = '0;
    for (int i = 0; i < N; i++) beat = lane_oh[i] ? word[i*TDATA_W +: TDATA_W] : beat;
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    if (pop) begin
      state_n = |rd[DATA_W +: N] ? UNPACK : IDLE;
      rem_n   = rd[DATA_W +: N];
    end else if (can_load) begin
      state_n = final_lane ? IDLE : UNPACK;
      rem_n   = rem & (rem - N'(1));
    end
  end

  always_ff @(posedge clk_i)
    if (push & ~rst_i) mem[wptr] <= {w_last_i, w_strb_i, w_data_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rem           <= '0;
      word          <= '0;
      hold_last     <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      cnt           <= '0;
      axis_tvalid_o <= 1'b0;
      axis_tdata_o  <= '0;
      axis_tlast_o  <= 1'b0;
    end else if (cke_i) begin
      state <= state_n;
      rem   <= rem_n;
      level <= level + LW'(push) - LW'(pop);
      if (push) wptr <= wptr + FIFO_DEPTH_LOG2'(1);
      if (pop) begin
        rptr      <= rptr + FIFO_DEPTH_LOG2'(1);
        word      <= rd[DATA_W-1:0];
        hold_last <= rd[EW-1];
      end
      if (can_load) begin
        axis_tvalid_o <= 1'b1;
        axis_tdata_o  <= beat;
        axis_tlast_o  <= lane_last;
        cnt           <= lane_last ? '0 : cnt + PKT_LEN_W'(1);
      end else if (axis_tready_i) begin
        axis_tvalid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_iob_axistream_out_pkt.sv
// tb_iob_axistream_out_pkt: vector table, directed corner cases and random traffic against a lane-level stream model
module tb_iob_axistream_out_pkt;
  logic        clk = 1'b0;
  logic        cke, rst, enable, auto_en, w_valid, w_last, w_ready;
  logic        f_empty, f_full, f_thr, tvalid, tready, tlast;
  logic [15:0] plen;
  logic [4:0]  thr, level;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [7:0]  tdata;
  int          checks = 0, errors = 0;
  logic [8:0]  got_q[$], exp_q[$];
  logic [15:0] mcnt = '0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    int          n;
    logic [31:0] ed;
    logic [3:0]  el;
  } vec_t;
  vec_t vecs[6];

  iob_axistream_out_pkt dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .enable_i(enable),
    .auto_last_en_i(auto_en), .pkt_len_i(plen), .threshold_i(thr),
    .w_valid_i(w_valid), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .w_ready_o(w_ready), .fifo_level_o(level), .fifo_empty_o(f_empty),
    .fifo_full_o(f_full), .fifo_threshold_o(f_thr),
    .axis_tvalid_o(tvalid), .axis_tready_i(tready),
    .axis_tdata_o(tdata), .axis_tlast_o(tlast)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic void model_push(logic [31:0] d, logic [3:0] s, logic l);
    logic fin, lst;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        fin  = (s >> (i + 1)) == 4'd0;
        lst  = (l & fin) | (auto_en & (plen != 0) & (mcnt == plen - 16'd1));
        exp_q.push_back({lst, d[8*i +: 8]});
        mcnt = lst ? 16'd0 : mcnt + 16'd1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      got_q.delete();
      exp_q.delete();
      mcnt = '0;
    end else if (cke) begin
      if (tvalid & tready) got_q.push_back({tlast, tdata});
      if (w_valid & w_ready) model_push(w_data, w_strb, w_last);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic [3:0] s, input logic l);
    w_valid = 1'b1;
    w_data  = d;
    w_strb  = s;
    w_last  = l;
    step();
    w_valid = 1'b0;
  endtask

  function automatic logic [15:0] lmask();
    logic [15:0] m = '0;
    for (int i = 0; i < got_q.size() && i < 16; i++) m[i] = got_q[i][8];
    return m;
  endfunction

  task automatic drain(input string name);
    int t = 0;
    while (t < 3000 && !(got_q.size() == exp_q.size() && f_empty && !tvalid)) begin
      step();
      t++;
    end
    repeat (3) step();
    chk({name, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s beat%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t, run;
    vecs[0] = '{32'h44332211, 4'b1111, 1'b1, 4, 32'h44332211, 4'b1000};
    vecs[1] = '{32'hDDCCBBAA, 4'b0101, 1'b1, 2, 32'h0000CCAA, 4'b0010};
    vecs[2] = '{32'h99999999, 4'b0000, 1'b1, 0, 32'h00000000, 4'b0000};
    vecs[3] = '{32'h88776655, 4'b1000, 1'b0, 1, 32'h00000088, 4'b0000};
    vecs[4] = '{32'h12345678, 4'b0110, 1'b0, 2, 32'h00003456, 4'b0000};
    vecs[5] = '{32'hAABBCCDD, 4'b1001, 1'b1, 2, 32'h0000AADD, 4'b0010};
    cke = 1'b1; rst = 1'b1; enable = 1'b1; auto_en = 1'b0; plen = '0; thr = 5'd4;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; tready = 1'b1;
    repeat (3) step();
    chk("reset outputs", {tvalid, tlast, tdata, level, f_empty, f_full, w_ready, f_thr},
        {1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1});
    rst = 1'b0;
    step();
    cke = 1'b0; w_valid = 1'b1; w_data = 32'hDEADBEEF; w_strb = 4'hF; w_last = 1'b1;
    step();
    step();
    chk("cke=0 level", level, 5'd0);
    chk("cke=0 w_ready", w_ready, 1'b1);
    w_valid = 1'b0; cke = 1'b1;
    step();
    wr(32'h44332211, 4'hF, 1'b1);
    step();
    chk("latency k+1 tvalid", tvalid, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("latency beat%0d", j), {tvalid, tlast, tdata}, {1'b1, j == 3, 8'(17 * (j + 1))});
    end
    step();
    chk("after word tvalid", tvalid, 1'b0);
    drain("latency stream");
    for (int v = 0; v < 6; v++) begin
      wr(vecs[v].d, vecs[v].s, vecs[v].l);
      repeat (8) step();
      chk($sformatf("vec%0d count", v), got_q.size(), vecs[v].n);
      for (int j = 0; j < vecs[v].n && j < got_q.size(); j++)
        chk($sformatf("vec%0d beat%0d", v, j), got_q[j], {vecs[v].el[j], vecs[v].ed[8*j +: 8]});
      got_q.delete();
      exp_q.delete();
    end
    wr(32'h44332211, 4'hF, 1'b1);
    repeat (3) step();
    chk("bp beat2 presented", {tvalid, tdata}, {1'b1, 8'h22});
    tready = 1'b0;
    repeat (3) begin
      step();
      chk("bp beat2 held", {tvalid, tdata}, {1'b1, 8'h22});
    end
    tready = 1'b1;
    repeat (6) step();
    chk("bp handshakes", got_q.size(), 4);
    drain("bp stream");
    auto_en = 1'b1; plen = 16'd3;
    wr(32'h04030201, 4'hF, 1'b0);
    wr(32'h08070605, 4'hF, 1'b1);
    wr(32'h0C0B0A09, 4'hF, 1'b0);
    repeat (16) step();
    chk("auto count", got_q.size(), 12);
    chk("auto tlast mask", lmask(), 16'h04A4);
    drain("auto stream");
    auto_en = 1'b0; plen = '0; enable = 1'b0;
    for (int i = 0; i < 16; i++) wr($urandom, 4'hF, i == 15);
    chk("full level", level, 5'd16);
    chk("full flags", {f_full, w_ready, f_thr, f_empty}, 4'b1000);
    wr(32'h12345678, 4'hF, 1'b0);
    chk("17th write rejected", level, 5'd16);
    enable = 1'b1;
    t = 0;
    while (!tvalid && t < 10) begin
      step();
      t++;
    end
    run = 0;
    while (tvalid && run < 100) begin
      run++;
      step();
    end
    chk("burst cycles", run, 64);
    chk("drained flags", {f_empty, f_thr, level}, {1'b1, 1'b1, 5'd0});
    drain("burst stream");
    auto_en = 1'b1; plen = 16'd3; tready = 1'b0;
    wr(32'hA4A3A2A1, 4'hF, 1'b0);
    wr(32'hB4B3B2B1, 4'hF, 1'b1);
    repeat (3) step();
    chk("pre-reset tvalid", tvalid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post-reset state", {tvalid, level, w_ready, f_empty}, {1'b0, 5'd0, 1'b1, 1'b1});
    tready = 1'b1;
    wr(32'h01020304, 4'hF, 1'b0);
    wr(32'h05060708, 4'hF, 1'b0);
    repeat (14) step();
    chk("post-reset count", got_q.size(), 8);
    chk("post-reset tlast mask", lmask(), 16'h0024);
    drain("post-reset stream");
    for (int r = 0; r < 3; r++) begin
      auto_en = r != 1;
      plen = 16'($urandom_range(0, 4));
      for (int c = 0; c < 250; c++) begin
        w_valid = $urandom_range(0, 1) == 1;
        w_data  = $urandom;
        w_strb  = 4'($urandom);
        w_last  = $urandom_range(0, 3) == 0;
        tready  = $urandom_range(0, 3) != 0;
        enable  = $urandom_range(0, 7) != 0;
        step();
      end
      w_valid = 1'b0; tready = 1'b1; enable = 1'b1;
      drain($sformatf("random%0d", r));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
